// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts a sync pattern, deserializes an MSB-first payload,
// checks optional even parity and holds the word in a one-entry valid/ready register.
module serial_frame_rx #(
  parameter int unsigned             DATA_W    = 8,
  parameter int unsigned             SYNC_W    = 4,
  parameter logic [SYNC_W-1:0]       SYNC_PAT  = 4'b1011,
  parameter bit                      PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              overrun,
  output logic              sync_lock
);

  localparam int unsigned HIST_W = SYNC_W - 1;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

  state_t              state, state_n;
  logic [HIST_W-1:0]   hist, hist_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [DATA_W-1:0]   payload, payload_n;
  logic [DATA_W-1:0]   data_out_n;
  logic                data_valid_n, parity_err_n, overrun_n, sync_lock_n;
  logic                done;
  logic [DATA_W-1:0]   word;
  logic                word_perr;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      hist       <= '0;
      cnt        <= '0;
      payload    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      sync_lock  <= 1'b0;
    end else begin
      state      <= state_n;
      hist       <= hist_n;
      cnt        <= cnt_n;
      payload    <= payload_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      parity_err <= parity_err_n;
      overrun    <= overrun_n;
      sync_lock  <= sync_lock_n;
    end
  end

  // Next-state, frame assembly and output handshake
  always_comb begin
    state_n      = state;
    hist_n       = hist;
    cnt_n        = cnt;
    payload_n    = payload;
    data_out_n   = data_out;
    data_valid_n = data_valid;
    parity_err_n = parity_err;
    overrun_n    = 1'b0;
    done         = 1'b0;
    word         = payload;
    word_perr    = 1'b0;

    if (data_valid && data_ready) data_valid_n = 1'b0;

    if (bit_en) begin
      case (state)
        HUNT: begin
          // hist keeps the last SYNC_W-1 bits; the window slides so overlaps are found
          hist_n = HIST_W'({hist, bit_in});
          if ({hist, bit_in} == SYNC_PAT) begin
            state_n = DATA;
            cnt_n   = '0;
          end
        end
        DATA: begin
          payload_n = {payload[DATA_W-2:0], bit_in};
          cnt_n     = cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            cnt_n = '0;
            if (PARITY_EN) begin
              state_n = PARITY;
            end else begin
              done = 1'b0 | 1'b1;
              word = payload_n;
            end
          end
        end
        PARITY: begin
          done      = 1'b1;
          word      = payload;
          word_perr = PARITY_EN & ((^payload) ^ bit_in);
        end
        default: state_n = HUNT;
      endcase
    end

    // Completion: next sync must be built from fresh bits
    if (done) begin
      state_n = HUNT;
      hist_n  = '0;
      if (!data_valid || data_ready) begin
        data_out_n   = word;
        parity_err_n = word_perr;
        data_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end

    sync_lock_n = (state_n == DATA) || (state_n == PARITY);
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx with default parameters.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       overrun;
  logic       sync_lock;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] last_acc = '0;
  int acc0, ovr0;

  serial_frame_rx dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .overrun    (overrun),
    .sync_lock  (sync_lock)
  );

  always #5 clk = ~clk;

  // Count handshakes and overrun cycles as seen at each rising edge
  always @(posedge clk) begin
    if (data_valid && data_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= data_out;
    end
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send n bits MSB first; gap idle cycles between consecutive bits
  task automatic send_bits(input logic [31:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      bit_in = bits[i];
      bit_en = 1'b1;
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bit_en = 1'b0;
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bit_en = 1'b0;
    bit_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_en = 1'b0; data_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data",  32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_perr",  32'(parity_err), 32'h0);
    check("rst_ovr",   32'(overrun), 32'h0);
    check("rst_lock",  32'(sync_lock), 32'h0);
    reset = 1'b0;

    // Basic frame
    data_ready = 1'b1;
    send_bits(32'b1011, 4, 0);
    idle();
    check("basic_lock", 32'(sync_lock), 32'h1);
    send_bits({8'hA5, 1'b0}, 9, 0);
    idle();
    check("basic_valid", 32'(data_valid), 32'h1);
    check("basic_data",  32'(data_out), 32'hA5);
    check("basic_perr",  32'(parity_err), 32'h0);
    check("basic_unlock", 32'(sync_lock), 32'h0);
    idle();
    check("basic_consumed", 32'(data_valid), 32'h0);
    check("basic_ovr", 32'(ovr_cnt), 32'h0);
    check("basic_acc", 32'(acc_cnt), 32'h1);

    // Parity error
    send_bits({4'b1011, 8'hA5, 1'b1}, 13, 0);
    idle();
    check("perr_valid", 32'(data_valid), 32'h1);
    check("perr_data",  32'(data_out), 32'hA5);
    check("perr_flag",  32'(parity_err), 32'h1);
    idle();
    check("perr_consumed", 32'(data_valid), 32'h0);

    // Sliding sync: 1,0,1,0,1,1 only matches on the 6th bit
    send_bits(32'b10101, 5, 0);
    idle();
    check("slide_nolock", 32'(sync_lock), 32'h0);
    send_bits(32'b1, 1, 0);
    idle();
    check("slide_lock", 32'(sync_lock), 32'h1);
    send_bits({8'h3C, 1'b0}, 9, 0);
    idle();
    check("slide_valid", 32'(data_valid), 32'h1);
    check("slide_data",  32'(data_out), 32'h3C);
    check("slide_perr",  32'(parity_err), 32'h0);
    idle();

    // Backpressure and overrun
    data_ready = 1'b0;
    ovr0 = ovr_cnt;
    send_bits({4'b1011, 8'hA5, 1'b0, 4'b1011, 8'h0F, 1'b0}, 26, 0);
    idle();
    check("ovr_pulse", 32'(overrun), 32'h1);
    check("ovr_valid", 32'(data_valid), 32'h1);
    check("ovr_data",  32'(data_out), 32'hA5);
    check("ovr_perr",  32'(parity_err), 32'h0);
    idle();
    check("ovr_one_cycle", 32'(overrun), 32'h0);
    check("ovr_count", 32'(ovr_cnt - ovr0), 32'h1);
    check("ovr_hold", 32'(data_out), 32'hA5);
    data_ready = 1'b1;
    idle();
    check("ovr_drain", 32'(data_valid), 32'h0);
    check("ovr_last_acc", 32'(last_acc), 32'hA5);

    // Gapped strobe
    send_bits({4'b1011, 8'hA5}, 12, 3);
    for (int g = 0; g < 3; g++) begin
      idle();
      check("gap_novalid", 32'(data_valid), 32'h0);
      check("gap_lock", 32'(sync_lock), 32'h1);
    end
    send_bits(32'b0, 1, 0);
    idle();
    check("gap_valid", 32'(data_valid), 32'h1);
    check("gap_data",  32'(data_out), 32'hA5);
    check("gap_perr",  32'(parity_err), 32'h0);
    idle();

    // Reset mid-frame with a pending word
    data_ready = 1'b0;
    send_bits({4'b1011, 8'h5A, 1'b0}, 13, 0);
    send_bits(32'b10111010, 8, 0);
    idle();
    check("pre_rst_valid", 32'(data_valid), 32'h1);
    check("pre_rst_lock", 32'(sync_lock), 32'h1);
    reset = 1'b1;
    #1;
    check("async_valid", 32'(data_valid), 32'h0);
    check("async_data",  32'(data_out), 32'h0);
    check("async_lock",  32'(sync_lock), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    data_ready = 1'b1;
    acc0 = acc_cnt;
    ovr0 = ovr_cnt;
    send_bits({4'b1011, 8'hA5, 1'b0}, 13, 0);
    idle();
    check("post_rst_data", 32'(data_out), 32'hA5);
    check("post_rst_valid", 32'(data_valid), 32'h1);
    idle();
    idle();
    check("post_rst_acc", 32'(acc_cnt - acc0), 32'h1);
    check("post_rst_word", 32'(last_acc), 32'hA5);
    check("post_rst_ovr", 32'(ovr_cnt - ovr0), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
